// File: rtl/accum_scheduler_pkg.sv
// Shared types, default constants and the round-robin pick helper for the
// accumulator scheduler.
package accum_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  localparam int NUM_REQ_DEF   = 4;
  localparam int DATA_W_DEF    = 8;
  localparam int MAX_BURST_DEF = 4;

  // Returns the first valid index at or after ptr, wrapping modulo numReq.
  // Sized for the largest supported requester count (8). When nothing is
  // valid the pointer itself is returned; callers gate on any-valid.
  function automatic logic [2:0] next_rr(input logic [2:0] ptr,
                                         input logic [7:0] valid,
                                         input int         numReq);
    int   idx;
    logic found;
    next_rr = ptr;
    found   = 1'b0;
    for (int k = 0; k < 8; k++) begin
      idx = (int'(ptr) + k) % numReq;
      if (k < numReq && !found && valid[idx[2:0]]) begin
        next_rr = idx[2:0];
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/accum_scheduler_if.sv
// Requester-side handshake bundle: per-requester valid, data, last and ready.
// The requesters drive the master side, the scheduler takes the slave side.
interface accum_scheduler_if #(
  parameter int NUM_REQ = accum_pkg::NUM_REQ_DEF,
  parameter int DATA_W  = accum_pkg::DATA_W_DEF
) ();

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_ready;

  modport master (output req_valid, output req_data, output req_last, input req_ready);
  modport slave  (input req_valid, input req_data, input req_last, output req_ready);

endinterface

// File: rtl/accum_scheduler_core.sv
// Accumulator datapath: the acc register with clear/add and the sticky
// saturation flag. Build macro ACCUM_SAT_EN selects saturating adds; without
// it the add wraps and sat_flag is tied low.
module accum_core
  import accum_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              beat_en,
  input  logic [DATA_W-1:0] beat_data,
  input  logic              acc_clear,
  output logic [DATA_W-1:0] acc_value,
  output logic              sat_flag
);

  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] base;

`ifdef ACCUM_SAT_EN
  logic [DATA_W:0] sum;
  logic            sat_q, sat_d;

  // Clear first, then add the beat and clamp on carry-out, latching the flag.
  always_comb begin
    base  = acc_clear ? '0 : acc_q;
    sum   = {1'b0, base} + {1'b0, beat_data};
    acc_d = base;
    sat_d = acc_clear ? 1'b0 : sat_q;
    if (beat_en) begin
      if (sum[DATA_W]) begin
        acc_d = '1;
        sat_d = 1'b1;
      end else begin
        acc_d = sum[DATA_W-1:0];
      end
    end
  end

  // Flag register, cleared by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) sat_q <= 1'b0;
    else       sat_q <= sat_d;
  end

  assign sat_flag = sat_q;
`else
  logic [DATA_W-1:0] sum;

  // Clear first, then add the beat modulo 2^DATA_W.
  always_comb begin
    base  = acc_clear ? '0 : acc_q;
    sum   = base + beat_data;
    acc_d = beat_en ? sum : base;
  end

  assign sat_flag = 1'b0;
`endif

  // Accumulator register; acc_value is its registered contents.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  assign acc_value = acc_q;

endmodule

// File: rtl/accum_scheduler.sv
// Round-robin scheduler sharing one accumulator among NUM_REQ requesters.
// Holds the grant FSM, rr_ptr, beat_cnt and ready generation, and drives the
// accum_core instance. ACCUM_SAT_EN (in accum_core) selects saturating adds.
module accum_scheduler
  import accum_pkg::*;
#(
  parameter int NUM_REQ   = NUM_REQ_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic                       clock,
  input  logic                       reset,
  accum_scheduler_if.slave           req,
  input  logic                       acc_clear,
  output logic [DATA_W-1:0]          acc_value,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       busy,
  output logic                       sat_flag
);

  localparam int              OW       = $clog2(NUM_REQ);
  localparam logic [OW-1:0]   LAST_IDX = OW'(NUM_REQ - 1);
  localparam logic [3:0]      MAX_CNT  = 4'(MAX_BURST);

  state_e            state_q, state_d;
  logic [OW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [OW-1:0]     owner_q, owner_d;
  logic [3:0]        beat_cnt_q, beat_cnt_d;

  logic [OW-1:0]     winner;
  logic [OW-1:0]     grant_idx;
  logic [OW-1:0]     rr_next;
  logic              any_valid;
  logic              beat_en;
  logic              beat_last;
  logic              grant_end;
  logic [3:0]        beat_num;
  logic [DATA_W-1:0] beat_data;

  // Arbitration and beat decode: who is granted, whether a beat lands this
  // cycle, and whether that beat closes the grant.
  always_comb begin
    any_valid = |req.req_valid;
    winner    = OW'(next_rr(3'(rr_ptr_q), 8'(req.req_valid), NUM_REQ));
    grant_idx = (state_q == BURST) ? owner_q : winner;
    beat_en   = !reset && ((state_q == BURST) ? req.req_valid[owner_q] : any_valid);
    beat_data = req.req_data[grant_idx*DATA_W +: DATA_W];
    beat_last = req.req_last[grant_idx];
    beat_num  = (state_q == BURST) ? beat_cnt_q + 4'd1 : 4'd1;
    grant_end = beat_last || (beat_num == MAX_CNT);
    rr_next   = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
  end

  // State register: FSM state, round-robin pointer, owner and beat count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Next-state: start, continue or close a grant on each accepted beat.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (beat_en) begin
          owner_d = winner;
          if (grant_end) begin
            rr_ptr_d   = rr_next;
            beat_cnt_d = '0;
          end else begin
            state_d    = BURST;
            beat_cnt_d = beat_num;
          end
        end
      end
      BURST: begin
        if (beat_en) begin
          if (grant_end) begin
            state_d    = IDLE;
            rr_ptr_d   = rr_next;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_num;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: one-hot ready to the grantee (none during reset), plus status.
  always_comb begin
    req.req_ready = '0;
    if (!reset) begin
      if (state_q == BURST)  req.req_ready[owner_q] = 1'b1;
      else if (any_valid)    req.req_ready[winner]  = 1'b1;
    end
    owner = owner_q;
    busy  = (state_q == BURST);
  end

  accum_core #(
    .DATA_W (DATA_W)
  ) u_core (
    .clock     (clock),
    .reset     (reset),
    .beat_en   (beat_en),
    .beat_data (beat_data),
    .acc_clear (acc_clear),
    .acc_value (acc_value),
    .sat_flag  (sat_flag)
  );

endmodule

// File: tb/tb_accum_scheduler.sv
// Self-checking bench for accum_scheduler: directed scenarios with literal
// expectations followed by randomized traffic, all compared every cycle
// against a queue-based behavioural model. ACCUM_SAT_EN selects the
// saturating expectations.
module tb_accum_scheduler;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         acc_clear = 1'b0;
  logic [W-1:0] acc_value;
  logic [1:0]   owner;
  logic         busy;
  logic         sat_flag;

  accum_scheduler_if #(.NUM_REQ(N), .DATA_W(W)) bus ();

  accum_scheduler #(.NUM_REQ(N), .DATA_W(W), .MAX_BURST(MB)) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (bus),
    .acc_clear (acc_clear),
    .acc_value (acc_value),
    .owner     (owner),
    .busy      (busy),
    .sat_flag  (sat_flag)
  );

  always #5 clock = ~clock;

  // Requester beat queues and stimulus controls
  int     dataQ[N][$];
  bit     lastQ[N][$];
  bit     validEn[N];
  bit     clearReq;
  bit     resetReq;
  bit     randMode;
  int     grantLog[$];

  // Behavioural model: current grant (if any), pointer, owner, acc, flag
  bit     mInGrant;
  int     mGrantee, mCount, mPtr, mOwner, mAcc;
  bit     mSat;
  logic [N-1:0] expReady;

  int errors = 0;
  int checks = 0;

  task automatic checkVal(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int logCode();
    int c = 0;
    foreach (grantLog[k]) c = c * 10 + grantLog[k] + 1;
    return c;
  endfunction

  task automatic modelReset();
    mInGrant = 1'b0;
    mGrantee = 0;
    mCount   = 0;
    mPtr     = 0;
    mOwner   = 0;
    mAcc     = 0;
    mSat     = 1'b0;
  endtask

  task automatic pushBeat(input int r, input int d, input bit l);
    dataQ[r].push_back(d);
    lastQ[r].push_back(l);
  endtask

  task automatic pushRandomBurst(input int r);
    int len;
    bit lastOk;
    len    = $urandom_range(6, 1);
    lastOk = ($urandom_range(3) != 0);
    for (int b = 0; b < len; b++)
      pushBeat(r, $urandom_range(255), lastOk && (b == len - 1));
  endtask

  task automatic clearAll();
    for (int i = 0; i < N; i++) begin
      dataQ[i].delete();
      lastQ[i].delete();
      validEn[i] = 1'b1;
    end
    grantLog.delete();
    clearReq = 1'b0;
  endtask

  // Drive the requesters from their queues; idle requesters present junk.
  task automatic applyStimulus();
    logic [N-1:0]   v;
    logic [N*W-1:0] d;
    logic [N-1:0]   l;
    if (randMode) begin
      for (int i = 0; i < N; i++) begin
        if (dataQ[i].size() == 0 && $urandom_range(7) == 0) pushRandomBurst(i);
        validEn[i] = ($urandom_range(3) != 0);
      end
      clearReq = ($urandom_range(15) == 0);
      reset    = ($urandom_range(599) == 0);
    end else begin
      reset = resetReq;
    end
    for (int i = 0; i < N; i++) begin
      if (dataQ[i].size() > 0 && validEn[i]) begin
        v[i]         = 1'b1;
        d[i*W +: W]  = 8'(dataQ[i][0]);
        l[i]         = lastQ[i][0];
      end else begin
        v[i]         = 1'b0;
        d[i*W +: W]  = 8'($urandom_range(255));
        l[i]         = 1'($urandom_range(1));
      end
    end
    bus.req_valid = v;
    bus.req_data  = d;
    bus.req_last  = l;
    acc_clear     = clearReq;
  endtask

  // Compare every output against the model for the current cycle.
  task automatic checkOutput();
    int w;
    if (reset) modelReset();
    expReady = '0;
    if (!reset) begin
      if (mInGrant) begin
        expReady[mGrantee] = 1'b1;
      end else begin
        w = -1;
        for (int k = N - 1; k >= 0; k--)
          if (bus.req_valid[(mPtr + k) % N]) w = (mPtr + k) % N;
        if (w >= 0) expReady[w] = 1'b1;
      end
    end
    checkVal("req_ready", 32'(bus.req_ready), 32'(expReady));
    checkVal("acc_value", 32'(acc_value), mAcc);
    checkVal("owner", 32'(owner), mOwner);
    checkVal("busy", 32'(busy), 32'(mInGrant));
    checkVal("sat_flag", 32'(sat_flag), 32'(mSat));
    for (int i = 0; i < N; i++)
      if (bus.req_ready[i] && bus.req_valid[i]) grantLog.push_back(i);
  endtask

  // Advance the model across the clock edge using its own expected ready.
  task automatic updateModel();
    int  idx, base, sum, cnt, d;
    bit  sat, l;
    if (reset) begin
      modelReset();
    end else begin
      base = acc_clear ? 0 : mAcc;
      sat  = acc_clear ? 1'b0 : mSat;
      sum  = base;
      idx  = -1;
      for (int i = 0; i < N; i++)
        if (expReady[i] && bus.req_valid[i]) idx = i;
      if (idx >= 0) begin
        d   = dataQ[idx].pop_front();
        l   = lastQ[idx].pop_front();
        sum = base + d;
`ifdef ACCUM_SAT_EN
        if (sum > 255) begin
          sum = 255;
          sat = 1'b1;
        end
`else
        sum = sum % 256;
`endif
        cnt    = (mInGrant ? mCount : 0) + 1;
        mOwner = idx;
        if (l || cnt == MB) begin
          mInGrant = 1'b0;
          mPtr     = (idx + 1) % N;
          mCount   = 0;
        end else begin
          mInGrant = 1'b1;
          mGrantee = idx;
          mCount   = cnt;
        end
      end
      mAcc = sum;
      mSat = sat;
    end
  endtask

  task automatic step();
    @(negedge clock);
    applyStimulus();
    #1;
    checkOutput();
    @(posedge clock);
    updateModel();
  endtask

  task automatic doReset();
    clearAll();
    resetReq = 1'b1;
    step();
    resetReq = 1'b0;
  endtask

  initial begin
    randMode = 1'b0;
    resetReq = 1'b1;
    modelReset();
    clearAll();

    // Reset state: ready stays low even with every requester valid
    for (int i = 0; i < N; i++) pushBeat(i, 1, 1'b1);
    @(negedge clock);
    applyStimulus();
    #1;
    checkVal("rst_ready", 32'(bus.req_ready), 0);
    checkVal("rst_acc", 32'(acc_value), 0);
    checkVal("rst_owner", 32'(owner), 0);
    checkVal("rst_busy", 32'(busy), 0);
    checkVal("rst_sat", 32'(sat_flag), 0);
    checkOutput();
    @(posedge clock);
    updateModel();
    doReset();

    // Single requester burst 5,10,20
    pushBeat(0, 5, 1'b0);
    pushBeat(0, 10, 1'b0);
    pushBeat(0, 20, 1'b1);
    step();
    #1 checkVal("t1_busy_on", 32'(busy), 1);
    step();
    step();
    #1;
    checkVal("t1_acc", 32'(acc_value), 35);
    checkVal("t1_busy_off", 32'(busy), 0);
    checkVal("t1_order", logCode(), 111);
    step();
    // Pointer now 1: req1 wins over req0
    grantLog.delete();
    pushBeat(0, 9, 1'b1);
    pushBeat(1, 11, 1'b1);
    step();
    step();
    #1;
    checkVal("t1_rrptr_order", logCode(), 21);
    checkVal("t1_acc2", 32'(acc_value), 55);

    // Fairness with single-beat bursts from everyone
    doReset();
    for (int i = 0; i < N; i++) begin
      pushBeat(i, i + 1, 1'b1);
      pushBeat(i, i + 1, 1'b1);
    end
    repeat (5) step();
    #1 checkVal("fair_order", logCode(), 12341);
    repeat (3) step();

    // MAX_BURST cap: req2 six unterminated beats, req3 competing
    doReset();
    for (int b = 0; b < 6; b++) pushBeat(2, 1, 1'b0);
    pushBeat(3, 9, 1'b1);
    repeat (9) step();
    #1;
    checkVal("cap_order", logCode(), 3333433);
    checkVal("cap_acc", 32'(acc_value), 15);
    checkVal("cap_busy", 32'(busy), 1);

    // Stall: owner drops valid for three cycles mid-burst
    doReset();
    pushBeat(1, 3, 1'b0);
    pushBeat(1, 4, 1'b0);
    pushBeat(1, 5, 1'b1);
    pushBeat(3, 50, 1'b1);
    step();
    validEn[1] = 1'b0;
    repeat (3) step();
    #1;
    checkVal("stall_ready", 32'(bus.req_ready), 32'h2);
    checkVal("stall_acc", 32'(acc_value), 3);
    checkVal("stall_busy", 32'(busy), 1);
    validEn[1] = 1'b1;
    repeat (3) step();
    #1;
    checkVal("stall_order", logCode(), 2224);
    checkVal("stall_acc_end", 32'(acc_value), 62);

    // Clear collisions and overflow
    doReset();
    pushBeat(0, 100, 1'b1);
    step();
    #1 checkVal("clr_pre", 32'(acc_value), 100);
    pushBeat(0, 7, 1'b1);
    clearReq = 1'b1;
    step();
    clearReq = 1'b0;
    #1 checkVal("clr_collide", 32'(acc_value), 7);
    pushBeat(0, 250, 1'b1);
    clearReq = 1'b1;
    step();
    clearReq = 1'b0;
    pushBeat(0, 10, 1'b1);
    step();
    #1;
`ifdef ACCUM_SAT_EN
    checkVal("ovf_acc", 32'(acc_value), 255);
    checkVal("ovf_sat", 32'(sat_flag), 1);
`else
    checkVal("ovf_acc", 32'(acc_value), 4);
    checkVal("ovf_sat", 32'(sat_flag), 0);
`endif
    clearReq = 1'b1;
    step();
    clearReq = 1'b0;
    #1;
    checkVal("clr_acc", 32'(acc_value), 0);
    checkVal("clr_sat", 32'(sat_flag), 0);

    // Reset during beat 2 of a burst, then re-arbitrate from pointer 0
    doReset();
    pushBeat(1, 5, 1'b1);
    step();
    pushBeat(2, 1, 1'b0);
    pushBeat(2, 2, 1'b0);
    pushBeat(2, 3, 1'b1);
    step();
    resetReq = 1'b1;
    step();
    #1;
    checkVal("mid_rst_ready", 32'(bus.req_ready), 0);
    checkVal("mid_rst_acc", 32'(acc_value), 0);
    checkVal("mid_rst_owner", 32'(owner), 0);
    checkVal("mid_rst_busy", 32'(busy), 0);
    resetReq = 1'b0;
    pushBeat(1, 7, 1'b1);
    grantLog.delete();
    step();
    #1 checkVal("mid_rst_regrant", logCode(), 2);
    repeat (4) step();

    // Randomized traffic against the model
    randMode = 1'b1;
    repeat (3000) step();
    randMode = 1'b0;
    resetReq = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/accum_scheduler.md
# accum_scheduler

Round-robin scheduler that shares one 8-bit accumulator datapath among several requesters. Each requester streams bursts of operand beats over a valid/ready handshake. The scheduler grants one requester at a time, forwards its accepted beats to the accumulator core as tock arguments, and releases the grant at burst end. It sits between requester logic and the single accumulator instance and owns all sequencing of that instance.

## Interface
- NUM_REQ, 4: number of requesters (2..8)
- DATA_W, 8: operand and accumulator width
- MAX_BURST, 4: maximum beats per grant (1..15)
- clock  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester beat valid
- req_data  in  NUM_REQ*DATA_W  per-requester operand; requester i uses bits [i*DATA_W +: DATA_W]
- req_last  in  NUM_REQ  marks the final beat of requester i's burst
- req_ready  out  NUM_REQ  per-requester beat accept; one-hot or zero
- acc_clear  in  1  synchronous clear of the accumulator
- acc_value  out  DATA_W  registered accumulator contents
- owner  out  $clog2(NUM_REQ)  index of the current or most recent grantee
- busy  out  1  high while in BURST
- sat_flag  out  1  sticky saturation indicator; tied 0 when ACCUM_SAT_EN is undefined

## Operation
- FSM states: IDLE, BURST.
- IDLE, no valid: hold state; req_ready = 0.
- IDLE, any valid: combinational round-robin pick of the first valid index at or after rr_ptr, wrapping modulo NUM_REQ.
  - req_ready[winner] = 1 in the same cycle, so the first beat is accepted immediately.
  - If that beat has req_last = 1, or MAX_BURST = 1, the grant ends and the FSM stays in IDLE.
  - Otherwise the FSM moves to BURST with owner = winner.
- BURST: req_ready[owner] = 1; all other ready bits are 0. A cycle where the owner's valid is 0 is a stall: the grant is held and beat_cnt is unchanged.
- Grant end occurs on the accepted beat that has req_last = 1 or that is beat number MAX_BURST, whichever comes first. On grant end: rr_ptr <= owner+1 (wrap); FSM -> IDLE.
- Accepted beat: acc <= acc + data, truncated to DATA_W bits (wraps 255+1 -> 0).
- acc_clear with no beat: acc <= 0.
- acc_clear in the same cycle as a beat: acc <= data. The clear applies first.
- req_valid and req_data of requesters that are not granted are ignored. Those requesters must hold their beat until ready.

## Timing
- Reset values: state IDLE, rr_ptr 0, owner 0, beat_cnt 0, acc_value 0, busy 0, sat_flag 0. req_ready is 0 while reset is asserted.
- acc_value reflects an accepted beat one cycle later.
- busy is registered. It is high the cycle after a multi-beat grant starts and low the cycle after grant end.
- Back-to-back grants: after grant end the FSM is in IDLE for one cycle. That cycle can already accept the next winner's first beat, so there is no bubble.
- Reset asserted mid-burst: the grant is abandoned immediately and all state returns to reset values. The interrupted requester re-arbitrates normally after reset.
- Maximum throughput is one beat per cycle.

## Configuration
- ACCUM_SAT_EN defined: the add saturates at 2^DATA_W-1. sat_flag sets on any saturating add and clears only on acc_clear or reset.
- ACCUM_SAT_EN undefined: the add wraps modulo 2^DATA_W and sat_flag is constant 0.

## Structure
- Package accum_pkg holds:
  - the state enum (IDLE, BURST)
  - the default constants for NUM_REQ, DATA_W and MAX_BURST
  - a function next_rr(ptr, valid) that returns the winner index
- One sub-module, accum_core, holds the acc register, the clear/add/saturate logic and sat_flag. Its inputs are clock, reset, beat_en, beat_data and acc_clear.
- The scheduler holds the FSM, rr_ptr, beat_cnt and ready generation.

## Test plan
- Single requester: req0 sends 3 beats (5, 10, 20; last on the third) -> three consecutive accepts; acc_value = 35; busy falls; rr_ptr = 1.
- Fairness: all 4 requesters continuously valid, 1-beat bursts -> grant order 0,1,2,3,0; no requester is skipped.
- MAX_BURST cap: req2 sends 6 beats of value 1 with no last -> 4 accepts, then release. A competing req3 is granted next. Beats 5–6 of req2 are accepted only on req2's following grant.
- Stall: owner drops valid for 3 cycles mid-burst -> grant held, other ready bits stay 0, acc_value unchanged.
- Clear collision: acc = 100, beat 7 accepted in the same cycle as acc_clear -> acc_value = 7.
  - Wrap build (ACCUM_SAT_EN undefined): 250 + 10 -> 4.
  - ACCUM_SAT_EN defined: 250 + 10 -> 255 and sat_flag = 1.
- Reset mid-burst: assert reset during beat 2 of a burst -> req_ready 0 at once; acc_value 0; owner 0. After release, the first valid requester is granted from rr_ptr 0.
